// File: rtl/irq_timer_unit_if.sv
// Register-port bundle between the core load/store path and irq_timer_unit.
// The master drives the strobes, address and write data; the slave returns registered read data.
interface irq_timer_unit_if;
  logic        re;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output re, output we, output addr, output wdata, input rdata);
  modport slave  (input re, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_timer_unit.sv
// Timer/interrupt unit: 64-bit mtime/mtimecmp driving ti, synchronised edge-triggered external lines driving ei.
// Optional macro TIMER_SHADOW_EN adds a shadow so MTIME_LO then MTIME_HI reads form a coherent 64-bit value.
module irq_timer_unit #(
  parameter int NUM_SRC     = 8,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  irq_timer_unit_if.slave    bus,
  input  logic [NUM_SRC-1:0] i_irq_src,
  output logic               o_ti,
  output logic               o_ei
);
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_IE          = 3'd4;
  localparam logic [2:0] A_IP          = 3'd5;
  localparam logic [2:0] A_CLAIM       = 3'd6;

  logic [PW-1:0]                        r_pre_cnt;
  logic [63:0]                          r_mtime;
  logic [63:0]                          r_mtimecmp;
  logic [NUM_SRC-1:0]                   r_ie;
  logic [NUM_SRC-1:0]                   r_ip;
  logic [NUM_SRC-1:0]                   r_edge_prev;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]  r_sync;
  logic [31:0]                          r_rdata;
  logic                                 r_ti;
  logic                                 r_ei;
`ifdef TIMER_SHADOW_EN
  logic [31:0]                          r_shadow;
`endif

  logic [2:0]         w_sel;
  logic               w_tick;
  logic [NUM_SRC-1:0] w_sync_out;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_hit;
  logic [NUM_SRC-1:0] w_claim_mask;
  logic [NUM_SRC-1:0] w_ip_nxt;
  logic [NUM_SRC-1:0] w_ie_nxt;
  logic [63:0]        w_mtime_nxt;
  logic [63:0]        w_mtimecmp_nxt;
  logic [31:0]        w_claim;
  logic [31:0]        w_rd_val;
  logic               w_unused_addr;

  assign w_sel         = bus.addr[4:2];
  assign w_unused_addr = ^bus.addr[1:0];
  assign w_tick        = (r_pre_cnt == PRE_LAST);
  assign w_sync_out    = r_sync[SYNC_STAGES-1];
  assign w_edge        = w_sync_out & ~r_edge_prev;
  assign w_hit         = r_ip & r_ie;
  // isolate the lowest pending-and-enabled bit
  assign w_claim_mask  = w_hit & (~w_hit + NUM_SRC'(1));

  always_comb begin
    w_claim = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_hit[i]) w_claim = 32'(i + 1);
    end
  end

  always_comb begin
    w_mtime_nxt    = r_mtime + 64'(w_tick);
    w_mtimecmp_nxt = r_mtimecmp;
    w_ie_nxt       = r_ie;
    w_ip_nxt       = r_ip;
    if (bus.we) begin
      case (w_sel)
        A_MTIME_LO:    w_mtime_nxt    = {r_mtime[63:32], bus.wdata};
        A_MTIME_HI:    w_mtime_nxt    = {bus.wdata, r_mtime[31:0]};
        A_MTIMECMP_LO: w_mtimecmp_nxt = {r_mtimecmp[63:32], bus.wdata};
        A_MTIMECMP_HI: w_mtimecmp_nxt = {bus.wdata, r_mtimecmp[31:0]};
        A_IE:          w_ie_nxt       = bus.wdata[NUM_SRC-1:0];
        A_IP:          w_ip_nxt       = r_ip & ~bus.wdata[NUM_SRC-1:0];
        default:       ;
      endcase
    end
    if (bus.re && (w_sel == A_CLAIM)) w_ip_nxt = w_ip_nxt & ~w_claim_mask;
    // a fresh edge always beats a clear or a claim in the same cycle
    w_ip_nxt = w_ip_nxt | w_edge;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      A_MTIME_LO:    w_rd_val = r_mtime[31:0];
`ifdef TIMER_SHADOW_EN
      A_MTIME_HI:    w_rd_val = r_shadow;
`else
      A_MTIME_HI:    w_rd_val = r_mtime[63:32];
`endif
      A_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
      A_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
      A_IE:          w_rd_val = 32'(r_ie);
      A_IP:          w_rd_val = 32'(r_ip);
      A_CLAIM:       w_rd_val = w_claim;
      default:       w_rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt   <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_ie        <= '0;
      r_ip        <= '0;
      r_edge_prev <= '0;
      r_sync      <= '0;
      r_rdata     <= '0;
      r_ti        <= 1'b0;
      r_ei        <= 1'b0;
`ifdef TIMER_SHADOW_EN
      r_shadow    <= '0;
`endif
    end else begin
      r_pre_cnt   <= w_tick ? '0 : r_pre_cnt + PW'(1);
      r_mtime     <= w_mtime_nxt;
      r_mtimecmp  <= w_mtimecmp_nxt;
      r_ie        <= w_ie_nxt;
      r_ip        <= w_ip_nxt;
      r_sync[0]   <= i_irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_edge_prev <= w_sync_out;
      r_ti        <= (w_mtime_nxt >= w_mtimecmp_nxt);
      r_ei        <= |(w_ip_nxt & w_ie_nxt);
      if (bus.re) r_rdata <= w_rd_val;
`ifdef TIMER_SHADOW_EN
      if (bus.re && (w_sel == A_MTIME_LO))      r_shadow <= r_mtime[63:32];
      else if (bus.we && (w_sel == A_MTIME_HI)) r_shadow <= bus.wdata;
`endif
    end
  end

  assign bus.rdata = r_rdata;
  assign o_ti      = r_ti;
  assign o_ei      = r_ei;
endmodule

// File: tb/tb_irq_timer_unit.sv
// Directed bench for irq_timer_unit: a register-access vector table plus hand-written timing sequences.
module tb_irq_timer_unit;
  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  logic       ti;
  logic       ei;

  irq_timer_unit_if bus ();

  irq_timer_unit #(.NUM_SRC(8), .PRESCALE(1), .SYNC_STAGES(2)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .i_irq_src (irq_src),
    .o_ti      (ti),
    .o_ei      (ei)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling clock edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic pulse(input int line);
    irq_src[line] = 1'b1;
    repeat (3) @(negedge clk);
    irq_src[line] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int k;
    bit ok;

    vecs[0]  = '{1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, 5'h10, 32'h0,         32'h0000_00FF};
    vecs[2]  = '{1'b1, 5'h10, 32'h0000_005A, 32'h0};
    vecs[3]  = '{1'b0, 5'h10, 32'h0,         32'h0000_005A};
    vecs[4]  = '{1'b0, 5'h13, 32'h0,         32'h0000_005A};
    vecs[5]  = '{1'b1, 5'h08, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b0, 5'h08, 32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b1, 5'h0C, 32'hCAFE_0001, 32'h0};
    vecs[8]  = '{1'b0, 5'h0E, 32'h0,         32'hCAFE_0001};
    vecs[9]  = '{1'b1, 5'h1C, 32'hDEAD_BEEF, 32'h0};
    vecs[10] = '{1'b0, 5'h1C, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 5'h18, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 5'h14, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 5'h10, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 5'h10, 32'h0,         32'h0};

    rst_n = 1'b0; irq_src = '0;
    bus.re = 1'b1; bus.we = 1'b0; bus.addr = 5'h18; bus.wdata = '0;

    // reset: outputs quiet even with a read strobe present
    repeat (3) @(negedge clk);
    check("reset_ti", {31'b0, ti}, 32'h0);
    check("reset_ei", {31'b0, ei}, 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    bus.re = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(5'h00, rd);
    check("mtime_after_10", rd, 32'd10);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // timer compare at 20
    bus_write(5'h0C, 32'h0);
    bus_write(5'h00, 32'h0);
    bus_write(5'h08, 32'd20);
    k = 1; ok = 1'b1;
    while (k < 20) begin
      if (ti !== 1'b0) ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check("ti_low_before_20", {31'b0, ok}, 32'h1);
    check("ti_high_at_20", {31'b0, ti}, 32'h1);
    bus_read(5'h00, rd);
    check("mtime_at_ti", rd, 32'd20);
    bus_write(5'h08, 32'hFFFF_FFFF);
    check("ti_drop_after_cmp_write", {31'b0, ti}, 32'h0);

    // same-cycle read and write of one register
    bus.re = 1'b1; bus.we = 1'b1; bus.addr = 5'h08; bus.wdata = 32'h55;
    @(negedge clk);
    bus.re = 1'b0; bus.we = 1'b0;
    check("rw_same_cycle_pre", bus.rdata, 32'hFFFF_FFFF);
    bus_read(5'h08, rd);
    check("rw_same_cycle_post", rd, 32'h55);

    // carry from LO into HI
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'h0);
    @(negedge clk);
    bus_read(5'h00, rd);
    check("carry_lo", rd, 32'h0);
    bus_read(5'h04, rd);
    check("carry_hi", rd, 32'h1);

    // coherent read across a carry
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'h0);
    bus_read(5'h00, rd);
    check("split_lo", rd, 32'hFFFF_FFFF);
    bus_read(5'h04, rd);
`ifdef TIMER_SHADOW_EN
    check("split_hi_shadow", rd, 32'h0);
`else
    check("split_hi_live", rd, 32'h1);
`endif

    // external edges, enable mask and claim order
    bus_write(5'h10, 32'h0A);
    pulse(3);
    pulse(1);
    bus_read(5'h14, rd);
    check("ip_after_pulses", rd, 32'h0A);
    check("ei_pending", {31'b0, ei}, 32'h1);
    bus_read(5'h18, rd);
    check("claim_first", rd, 32'd2);
    check("ei_after_first_claim", {31'b0, ei}, 32'h1);
    bus_read(5'h18, rd);
    check("claim_second", rd, 32'd4);
    check("ei_after_second_claim", {31'b0, ei}, 32'h0);
    bus_read(5'h18, rd);
    check("claim_empty", rd, 32'd0);
    pulse(2);
    bus_read(5'h14, rd);
    check("ip_masked_line", rd, 32'h04);
    check("ei_masked_line", {31'b0, ei}, 32'h0);
    bus_write(5'h14, 32'h04);
    bus_read(5'h14, rd);
    check("ip_w1c", rd, 32'h0);

    // held line sets once; clear colliding with a new edge
    bus_write(5'h10, 32'h01);
    irq_src[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(5'h14, rd);
    check("held_sets_ip", rd, 32'h1);
    bus_write(5'h14, 32'h1);
    repeat (5) @(negedge clk);
    bus_read(5'h14, rd);
    check("held_no_reset", rd, 32'h0);
    irq_src[0] = 1'b0;
    repeat (3) @(negedge clk);
    irq_src[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(5'h14, 32'h1);
    bus_read(5'h14, rd);
    check("set_beats_clear", rd, 32'h1);
    check("ei_after_collision", {31'b0, ei}, 32'h1);

    // asynchronous reset mid-operation
    check("pre_reset_ti", {31'b0, ti}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ti", {31'b0, ti}, 32'h0);
    check("async_ei", {31'b0, ei}, 32'h0);
    check("async_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(5'h10, 32'h01);
    check("sync_fill_1", {31'b0, ei}, 32'h0);
    @(negedge clk);
    check("sync_fill_2", {31'b0, ei}, 32'h0);
    @(negedge clk);
    check("sync_fill_3", {31'b0, ei}, 32'h1);
    bus_read(5'h08, rd);
    check("cmp_lo_reset", rd, 32'hFFFF_FFFF);
    bus_read(5'h0C, rd);
    check("cmp_hi_reset", rd, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
